lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem.sv | 245 ++++++++++++++++++++++++
 tb/tb_lsu_mem.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// lsu_mem: memory stage of the pipeline. Issues at most one data-memory
// access at a time, stalls upstream until the memory acknowledges, and
// writes the load/ALU result into the M/W register.
//
// Ports
//   CLK, NRST                   clock, synchronous active-low reset
//   pcM, instM, rdM, resultM,   E/M register contents (resultM is the
//   store_dataM, mem_storeM,    effective address for memory ops)
//   mem_loadM, reg_writeM
//   dmem_req/we/addr/wdata/be   registered data-memory request, held
//                               constant while waiting for dmem_ack
//   dmem_ack, dmem_rdata        memory response
//   pcW, instW, rdW, wb_dataW,  M/W register
//   reg_writeW
//   stall_M                     combinational; freezes all upstream stages
//   misalign_err                one-cycle pulse for a misaligned access
module lsu_mem (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [12:0] pcM,
    input  logic [31:0] instM,
    input  logic [4:0]  rdM,
    input  logic [31:0] resultM,
    input  logic [31:0] store_dataM,
    input  logic [1:0]  mem_storeM,
    input  logic [2:0]  mem_loadM,
    input  logic        reg_writeM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [12:0] pcW,
    output logic [31:0] instW,
    output logic [4:0]  rdW,
    output logic [31:0] wb_dataW,
    output logic        reg_writeW,
    output logic        stall_M,
    output logic        misalign_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    // fields of the in-flight access
    logic        st_q, st_d;
    logic [2:0]  ld_q, ld_d;
    logic [1:0]  off_q, off_d;
    logic [12:0] lpc_q, lpc_d;
    logic [31:0] linst_q, linst_d;
    logic [4:0]  lrd_q, lrd_d;
    logic        lrw_q, lrw_d;
    // M/W register
    logic [12:0] pcW_q, pcW_d;
    logic [31:0] instW_q, instW_d, wb_q, wb_d;
    logic [4:0]  rdW_q, rdW_d;
    logic        rwW_q, rwW_d, merr_q, merr_d;

    logic        is_store, is_load, access, half_op, word_op, misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    // Decode; a store takes priority over a simultaneous load code.
    always_comb begin
        is_store   = (mem_storeM != 2'd0);
        is_load    = (mem_loadM >= 3'd1) && (mem_loadM <= 3'd5);
        access     = is_store || is_load;
        half_op    = is_store ? (mem_storeM == 2'd2)
                              : ((mem_loadM == 3'd2) || (mem_loadM == 3'd5));
        word_op    = is_store ? (mem_storeM == 2'd3) : (mem_loadM == 3'd3);
        misaligned = access && ((half_op && resultM[0]) ||
                                (word_op && (resultM[1:0] != 2'b00)));
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = '0;
        case (mem_storeM)
            2'd1: begin
                be_new    = 4'b0001 << resultM[1:0];
                wdata_new = {4{store_dataM[7:0]}};
            end
            2'd2: begin
                be_new    = resultM[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_dataM[15:0]}};
            end
            2'd3: wdata_new = store_dataM;
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_q)
            3'd1:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_val = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_val = {24'd0, ld_byte};
            3'd5:    ld_val = {16'd0, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    // Any stalled edge loads a bubble, so the W defaults are all zero.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        st_d    = st_q;
        ld_d    = ld_q;
        off_d   = off_q;
        lpc_d   = lpc_q;
        linst_d = linst_q;
        lrd_d   = lrd_q;
        lrw_d   = lrw_q;
        pcW_d   = '0;
        instW_d = '0;
        rdW_d   = '0;
        wb_d    = '0;
        rwW_d   = 1'b0;
        merr_d  = 1'b0;
        stall_M = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    stall_M = 1'b1;
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {resultM[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    st_d    = is_store;
                    ld_d    = mem_loadM;
                    off_d   = resultM[1:0];
                    lpc_d   = pcM;
                    linst_d = instM;
                    lrd_d   = rdM;
                    lrw_d   = reg_writeM;
                end else if (misaligned) begin
                    merr_d  = 1'b1;
                    pcW_d   = pcM;
                    instW_d = instM;
                    rdW_d   = rdM;
                end else begin
                    pcW_d   = pcM;
                    instW_d = instM;
                    rdW_d   = rdM;
                    wb_d    = resultM;
                    rwW_d   = reg_writeM;
                end
            end
            default: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                    pcW_d   = lpc_q;
                    instW_d = linst_q;
                    rdW_d   = lrd_q;
                    wb_d    = st_q ? 32'd0 : ld_val;
                    rwW_d   = st_q ? 1'b0 : lrw_q;
                end else begin
                    stall_M = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            st_q    <= 1'b0;
            ld_q    <= '0;
            off_q   <= '0;
            lpc_q   <= '0;
            linst_q <= '0;
            lrd_q   <= '0;
            lrw_q   <= 1'b0;
            pcW_q   <= '0;
            instW_q <= '0;
            rdW_q   <= '0;
            wb_q    <= '0;
            rwW_q   <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            st_q    <= st_d;
            ld_q    <= ld_d;
            off_q   <= off_d;
            lpc_q   <= lpc_d;
            linst_q <= linst_d;
            lrd_q   <= lrd_d;
            lrw_q   <= lrw_d;
            pcW_q   <= pcW_d;
            instW_q <= instW_d;
            rdW_q   <= rdW_d;
            wb_q    <= wb_d;
            rwW_q   <= rwW_d;
            merr_q  <= merr_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign pcW          = pcW_q;
    assign instW        = instW_q;
    assign rdW          = rdW_q;
    assign wb_dataW     = wb_q;
    assign reg_writeW   = rwW_q;
    assign misalign_err = merr_q;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed vector table plus randomized operations for lsu_mem,
// with expected values from a word-level reference model.
module tb_lsu_mem;

    logic        CLK = 1'b0;
    logic        NRST;
    logic [12:0] pcM;
    logic [31:0] instM;
    logic [4:0]  rdM;
    logic [31:0] resultM;
    logic [31:0] store_dataM;
    logic [1:0]  mem_storeM;
    logic [2:0]  mem_loadM;
    logic        reg_writeM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [12:0] pcW;
    logic [31:0] instW;
    logic [4:0]  rdW;
    logic [31:0] wb_dataW;
    logic        reg_writeW;
    logic        stall_M;
    logic        misalign_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    lsu_mem dut (
        .CLK(CLK), .NRST(NRST),
        .pcM(pcM), .instM(instM), .rdM(rdM), .resultM(resultM),
        .store_dataM(store_dataM), .mem_storeM(mem_storeM),
        .mem_loadM(mem_loadM), .reg_writeM(reg_writeM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pcW(pcW), .instW(instW), .rdW(rdW), .wb_dataW(wb_dataW),
        .reg_writeW(reg_writeW), .stall_M(stall_M), .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int unsigned dly;
        logic        rw_in;
        logic        e_mem;
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_wb;
        logic        e_rw;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: operand size, alignment, lane and extension by arithmetic.
    task automatic model(input logic [1:0] st, input logic [2:0] ld,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input logic rw_in,
                         output logic e_mem, output logic e_mis,
                         output logic [3:0] e_be, output logic [31:0] e_wd,
                         output logic [31:0] e_wb, output logic e_rw);
        int unsigned size, off;
        bit is_st, is_ld, acc;
        logic [63:0] mask;
        logic [31:0] v;
        is_st = (st != 0);
        is_ld = (ld >= 1) && (ld <= 5);
        acc   = is_st || is_ld;
        if (is_st) size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
        else       size = (ld == 1 || ld == 4) ? 1 : (ld == 2 || ld == 5) ? 2 : 4;
        off   = a % 4;
        e_mis = acc && (off % size != 0);
        e_mem = acc && !e_mis;
        e_be  = 4'hF;
        e_wd  = 0;
        e_wb  = 0;
        e_rw  = 0;
        if (!acc) begin
            e_wb = a;
            e_rw = rw_in;
        end else if (e_mem && is_st) begin
            e_be = 4'(((1 << size) - 1) << off);
            if (size == 1)      e_wd = {24'd0, sd[7:0]} * 32'h0101_0101;
            else if (size == 2) e_wd = {16'd0, sd[15:0]} * 32'h0001_0001;
            else                e_wd = sd;
        end else if (e_mem) begin
            mask = (64'd1 << (8 * size)) - 1;
            v    = (rd >> (8 * off)) & mask[31:0];
            if ((ld == 1 || ld == 2) && v[8 * size - 1]) v = v | ~mask[31:0];
            e_wb = v;
            e_rw = rw_in;
        end
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic run_op(input vec_t v);
        logic [12:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        int unsigned stalls;
        pc   = 13'($urandom);
        inst = $urandom;
        rd   = 5'($urandom);
        pcM = pc; instM = inst; rdM = rd; resultM = v.addr;
        store_dataM = v.sdata; mem_storeM = v.st; mem_loadM = v.ld;
        reg_writeM = v.rw_in;
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        stalls = 0;
        if (stall_M) stalls++;
        chk({v.name, " stall_accept"}, 32'(stall_M), 32'(v.e_mem));
        @(posedge CLK); #1;
        if (!v.e_mem) begin
            chk({v.name, " req_none"}, 32'(dmem_req), 0);
            chk({v.name, " merr"}, 32'(misalign_err), 32'(v.e_mis));
            chk({v.name, " pcW"}, 32'(pcW), 32'(pc));
            chk({v.name, " instW"}, instW, inst);
            chk({v.name, " rdW"}, 32'(rdW), 32'(rd));
            chk({v.name, " wb"}, wb_dataW, v.e_wb);
            chk({v.name, " rw"}, 32'(reg_writeW), 32'(v.e_rw));
            return;
        end
        chk({v.name, " merr_low"}, 32'(misalign_err), 0);
        for (int unsigned i = 0; i <= v.dly; i++) begin
            // upstream contents must not matter while the access is pending
            pcM = 13'($urandom); instM = $urandom; rdM = 5'($urandom);
            resultM = $urandom; store_dataM = $urandom;
            mem_storeM = 2'($urandom); mem_loadM = 3'($urandom);
            reg_writeM = 1'($urandom);
            dmem_ack   = (i == v.dly);
            dmem_rdata = (i == v.dly) ? v.rdata : $urandom;
            #1;
            if (stall_M) stalls++;
            chk({v.name, " req"}, 32'(dmem_req), 1);
            chk({v.name, " we"}, 32'(dmem_we), 32'(v.st != 0));
            chk({v.name, " addr"}, dmem_addr, v.addr & ~32'd3);
            chk({v.name, " be"}, 32'(dmem_be), 32'(v.e_be));
            chk({v.name, " wdata"}, dmem_wdata, v.e_wd);
            chk({v.name, " bubble"}, {pcW, rdW, reg_writeW, wb_dataW[12:0]}, 0);
            chk({v.name, " bubble_inst"}, instW, 0);
            @(posedge CLK); #1;
        end
        dmem_ack = 1'b0;
        chk({v.name, " req_drop"}, 32'(dmem_req), 0);
        chk({v.name, " stall_cycles"}, stalls, v.dly + 1);
        chk({v.name, " pcW"}, 32'(pcW), 32'(pc));
        chk({v.name, " instW"}, instW, inst);
        chk({v.name, " rdW"}, 32'(rdW), 32'(rd));
        chk({v.name, " wb"}, wb_dataW, v.e_wb);
        chk({v.name, " rw"}, 32'(reg_writeW), 32'(v.e_rw));
        chk({v.name, " merr"}, 32'(misalign_err), 0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " req"}, 32'(dmem_req), 0);
        chk({nm, " we"}, 32'(dmem_we), 0);
        chk({nm, " addr"}, dmem_addr, 0);
        chk({nm, " wdata"}, dmem_wdata, 0);
        chk({nm, " be"}, 32'(dmem_be), 0);
        chk({nm, " pcW"}, 32'(pcW), 0);
        chk({nm, " instW"}, instW, 0);
        chk({nm, " rdW"}, 32'(rdW), 0);
        chk({nm, " wb"}, wb_dataW, 0);
        chk({nm, " rw"}, 32'(reg_writeW), 0);
        chk({nm, " merr"}, 32'(misalign_err), 0);
    endtask

    initial begin
        vec_t rv;
        //          name        st    ld    addr           sdata          rdata          d  rw  mem mis be       wdata          wb             rw
        vecs[0]  = '{"lb_sext",  2'd0, 3'd1, 32'h0000_1003, 32'h0,         32'h80FF_1234, 1, 1, 1, 0, 4'b1111, 32'h0,         32'hFFFF_FF80, 1};
        vecs[1]  = '{"sh_hi",    2'd2, 3'd0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         0, 1, 1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0};
        vecs[2]  = '{"lw_mis",   2'd0, 3'd3, 32'h0000_0006, 32'h0,         32'h0,         0, 1, 0, 1, 4'b0000, 32'h0,         32'h0,         0};
        vecs[3]  = '{"lhu_wait", 2'd0, 3'd5, 32'h0000_0002, 32'h0,         32'h8001_0000, 3, 1, 1, 0, 4'b1111, 32'h0,         32'h0000_8001, 1};
        vecs[4]  = '{"alu",      2'd0, 3'd0, 32'h1234_5678, 32'h0,         32'h0,         0, 1, 0, 0, 4'b0000, 32'h0,         32'h1234_5678, 1};
        vecs[5]  = '{"sb_off1",  2'd1, 3'd0, 32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 0, 1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         0};
        vecs[6]  = '{"sw",       2'd3, 3'd0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         2, 1, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,         0};
        vecs[7]  = '{"lh_neg",   2'd0, 3'd2, 32'h0000_0002, 32'h0,         32'h8000_1234, 0, 1, 1, 0, 4'b1111, 32'h0,         32'hFFFF_8000, 1};
        vecs[8]  = '{"lbu",      2'd0, 3'd4, 32'h0000_0002, 32'h0,         32'h12AB_3456, 1, 1, 1, 0, 4'b1111, 32'h0,         32'h0000_00AB, 1};
        vecs[9]  = '{"sh_mis",   2'd2, 3'd0, 32'h0000_0001, 32'h1111_2222, 32'h0,         0, 1, 0, 1, 4'b0000, 32'h0,         32'h0,         0};
        vecs[10] = '{"st_wins",  2'd3, 3'd1, 32'h0000_0010, 32'h1122_3344, 32'hFFFF_FFFF, 0, 1, 1, 0, 4'b1111, 32'h1122_3344, 32'h0,         0};
        vecs[11] = '{"ld6_none", 2'd0, 3'd6, 32'hABCD_0001, 32'h0,         32'h0,         0, 1, 0, 0, 4'b0000, 32'h0,         32'hABCD_0001, 1};
        vecs[12] = '{"lb_off3",  2'd0, 3'd1, 32'h0000_0007, 32'h0,         32'h7F00_0000, 0, 1, 1, 0, 4'b1111, 32'h0,         32'h0000_007F, 1};
        vecs[13] = '{"sw_mis",   2'd3, 3'd0, 32'h0000_0002, 32'h5555_AAAA, 32'h0,         0, 1, 0, 1, 4'b0000, 32'h0,         32'h0,         0};
        vecs[14] = '{"sb_off3",  2'd1, 3'd0, 32'h0000_0003, 32'h1234_5678, 32'h0,         0, 0, 1, 0, 4'b1000, 32'h7878_7878, 32'h0,         0};

        NRST = 1'b0;
        pcM = '0; instM = '0; rdM = '0; resultM = '0; store_dataM = '0;
        mem_storeM = '0; mem_loadM = '0; reg_writeM = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        chk("reset stall", 32'(stall_M), 0);
        NRST = 1'b1;

        foreach (vecs[k]) run_op(vecs[k]);

        for (int n = 0; n < 150; n++) begin
            rv.name  = "rand";
            rv.st    = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom);
            rv.ld    = 3'($urandom);
            rv.addr  = $urandom;
            rv.sdata = $urandom;
            rv.rdata = $urandom;
            rv.dly   = $urandom_range(0, 3);
            rv.rw_in = 1'($urandom);
            model(rv.st, rv.ld, rv.addr, rv.sdata, rv.rdata, rv.rw_in,
                  rv.e_mem, rv.e_mis, rv.e_be, rv.e_wd, rv.e_wb, rv.e_rw);
            run_op(rv);
        end

        // Reset while waiting for the memory, then a late acknowledge.
        pcM = 13'h0AA; instM = 32'h1234_0003; rdM = 5'd9; resultM = 32'h40;
        store_dataM = '0; mem_storeM = 2'd0; mem_loadM = 3'd3; reg_writeM = 1'b1;
        dmem_ack = 1'b0;
        #1;
        chk("rstwait accept_stall", 32'(stall_M), 1);
        @(posedge CLK); #1;
        chk("rstwait req", 32'(dmem_req), 1);
        NRST = 1'b0;
        @(posedge CLK); #1;
        check_all_zero("rstwait");
        NRST = 1'b1;
        mem_loadM = 3'd0; reg_writeM = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rstwait idle_stall", 32'(stall_M), 0);
        @(posedge CLK); #1;
        chk("late_ack req", 32'(dmem_req), 0);
        chk("late_ack rw", 32'(reg_writeW), 0);
        chk("late_ack wb", wb_dataW, 32'h40);
        chk("late_ack stall", 32'(stall_M), 0);
        dmem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
